// File: rtl/layer_result_sink_pkg.sv
// Shared definitions for layer_result_sink: exception tags, canonical NaN, FSM states.
package layer_result_sink_pkg;

  localparam logic [1:0]  EXC_ZERO   = 2'b00;
  localparam logic [1:0]  EXC_NORMAL = 2'b01;
  localparam logic [1:0]  EXC_INF    = 2'b10;
  localparam logic [1:0]  EXC_NAN    = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/layer_result_sink_exc_to_ieee.sv
// exc_to_ieee: combinational map from {exc[1:0], ieee[31:0]} to a plain IEEE-754 single.
module exc_to_ieee
  import layer_result_sink_pkg::*;
(
  input  logic [33:0] in_word,
  output logic [31:0] out_word
);

  logic [1:0] exc;
  logic       sign;

  assign exc  = in_word[33:32];
  assign sign = in_word[31];

  always_comb begin
    out_word = QNAN;
    case (exc)
      EXC_ZERO:   out_word = {sign, 31'b0};
      EXC_NORMAL: out_word = in_word[31:0];
      EXC_INF:    out_word = {sign, 8'hFF, 23'b0};
      default:    out_word = QNAN;
    endcase
  end

endmodule

// File: rtl/layer_result_sink.sv
// layer_result_sink: captures a DEPTH-word burst and serves IEEE-converted words on a registered read port.
// Optional sticky exception flags are built only when LAYER_RESULT_SINK_EXC_FLAGS_EN is defined.
module layer_result_sink
  import layer_result_sink_pkg::*;
#(
  parameter  int BIT_WIDTH  = 32,
  parameter  int EXTRA_BITS = 2,
  parameter  int DEPTH      = 4,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic                          IN_VALID,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] IN_DATA,
  output logic                          IN_READY,
  output logic                          DONE,
  output logic [ADDR_W:0]               COUNT,
  input  logic                          RD_EN,
  input  logic [ADDR_W-1:0]             RD_ADDR,
  output logic [BIT_WIDTH-1:0]          RD_DATA,
  output logic                          RD_VALID,
  output logic [2:0]                    EXC_SEEN
);

  localparam int WORD_W = BIT_WIDTH + EXTRA_BITS;

  state_t                   state_q, state_d;
  logic [ADDR_W:0]          count_q, count_d;
  logic [BIT_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0]        mem_q [DEPTH];

  logic                     accept;
  logic                     start_acc;
  logic                     rd_in_range;
  logic [WORD_W-1:0]        rd_word;
  logic [BIT_WIDTH-1:0]     rd_conv;

  // Ready/done come straight from the state register so no input reaches them.
  assign IN_READY  = (state_q == ST_CAPTURE);
  assign DONE      = (state_q == ST_FULL);
  assign COUNT     = count_q;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;

  assign accept    = IN_VALID & IN_READY;
  assign start_acc = START & (state_q != ST_CAPTURE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_FULL: begin
        if (START) begin
          state_d = ST_CAPTURE;
          count_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          count_d = count_q + (ADDR_W+1)'(1);
          if (count_q == (ADDR_W+1)'(DEPTH-1)) state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Storage is left uncleared by reset so partial bursts stay readable.
  always_ff @(posedge CLK) begin
    if (accept) mem_q[count_q[ADDR_W-1:0]] <= IN_DATA;
  end

  assign rd_in_range = ({1'b0, RD_ADDR} < (ADDR_W+1)'(DEPTH));
  assign rd_word     = rd_in_range ? mem_q[RD_ADDR] : '0;

  exc_to_ieee u_exc_to_ieee (
    .in_word  (rd_word),
    .out_word (rd_conv)
  );

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = RD_EN;
    if (RD_EN) rd_data_d = rd_in_range ? rd_conv : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef LAYER_RESULT_SINK_EXC_FLAGS_EN
  logic [2:0] exc_seen_q, exc_seen_d;

  always_comb begin
    exc_seen_d = exc_seen_q;
    if (start_acc) begin
      exc_seen_d = '0;
    end else if (accept) begin
      case (IN_DATA[WORD_W-1 -: 2])
        EXC_NAN:    exc_seen_d = exc_seen_q | 3'b100;
        EXC_INF:    exc_seen_d = exc_seen_q | 3'b010;
        EXC_ZERO:   exc_seen_d = exc_seen_q | 3'b001;
        EXC_NORMAL: exc_seen_d = exc_seen_q;
        default:    exc_seen_d = exc_seen_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) exc_seen_q <= '0;
    else       exc_seen_q <= exc_seen_d;
  end

  assign EXC_SEEN = exc_seen_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign EXC_SEEN = 3'b000;
`endif

endmodule
